// File: rtl/bit_serial_sequencer.sv
// Bit-clock and bit/round counter sequencer for the bit-serial SHA-256 datapath.
// One start-to-done job covers ROUNDS words of W_WORD bits, one bit per bclk period.
module bit_serial_sequencer #(
  parameter int W_WORD = 32,
  parameter int ROUNDS = 64,
  parameter int HALF   = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        abort,
  output logic                                        bclk,
  output logic [((W_WORD > 1) ? $clog2(W_WORD) : 1)-1:0] counter,
  output logic [((ROUNDS > 1) ? $clog2(ROUNDS) : 1)-1:0] round,
  output logic                                        word_first,
  output logic                                        word_last,
  output logic                                        busy,
  output logic                                        done
);

  localparam int CW = (W_WORD > 1) ? $clog2(W_WORD) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int PW = (HALF   > 1) ? $clog2(HALF)   : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(W_WORD - 1);
  localparam logic [RW-1:0] RND_MAX = RW'(ROUNDS - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [RW-1:0] round_q, round_d;
  logic          bclk_q, bclk_d;
  logic          word_first_q, word_first_d;
  logic          word_last_q, word_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    counter_d    = counter_q;
    round_d      = round_q;
    bclk_d       = bclk_q;
    busy_d       = busy_q;
    word_first_d = 1'b0;
    word_last_d  = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          phase_d = '0;
          bclk_d  = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          // cancel discards any pending bclk edge and leaves no done pulse
          state_d   = IDLE;
          bclk_d    = 1'b0;
          counter_d = '0;
          round_d   = '0;
          phase_d   = '0;
          busy_d    = 1'b0;
        end else if (phase_q == PH_MAX) begin
          phase_d = '0;
          bclk_d  = ~bclk_q;
          if (!bclk_q) begin
            word_first_d = (counter_q == '0);
          end else if (counter_q == CNT_MAX) begin
            // bit index wraps and the word index advances on the same falling edge
            counter_d   = '0;
            word_last_d = 1'b1;
            if (round_q == RND_MAX) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              round_d = '0;
            end else begin
              round_d = round_q + 1'b1;
            end
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      counter_q    <= '0;
      round_q      <= '0;
      bclk_q       <= 1'b0;
      word_first_q <= 1'b0;
      word_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      counter_q    <= counter_d;
      round_q      <= round_d;
      bclk_q       <= bclk_d;
      word_first_q <= word_first_d;
      word_last_q  <= word_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bclk       = bclk_q;
  assign counter    = counter_q;
  assign round      = round_q;
  assign word_first = word_first_q;
  assign word_last  = word_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bit_serial_sequencer.sv
// Scoreboard bench: a default-sized sequencer (a) and a tiny W_WORD=4/ROUNDS=3/HALF=1 one (b).
module tb_bit_serial_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic bclk_a, wf_a, wl_a, busy_a, done_a;
  logic bclk_b, wf_b, wl_b, busy_b, done_b;
  logic [4:0] cnt_a;
  logic [5:0] rnd_a;
  logic [1:0] cnt_b, rnd_b;

  int total = 0;
  int bad = 0;
  int ncyc = 0;

  typedef struct { int cyc; int rises; } done_exp_t;
  typedef struct { int cnt; int rnd; } rise_exp_t;
  done_exp_t qa[$];
  done_exp_t qb[$];
  rise_exp_t qr[$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  bit_serial_sequencer u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .bclk(bclk_a),
    .counter(cnt_a), .round(rnd_a), .word_first(wf_a), .word_last(wl_a),
    .busy(busy_a), .done(done_a)
  );

  bit_serial_sequencer #(.W_WORD(4), .ROUNDS(3), .HALF(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .bclk(bclk_b),
    .counter(cnt_b), .round(rnd_b), .word_first(wf_b), .word_last(wl_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor a: done timing, rise count per job, counter stability across rises
  initial begin : mon_a
    logic prev_b;
    int rises;
    int last_fall;
    done_exp_t e;
    prev_b = 1'b0; rises = 0; last_fall = 0;
    forever begin
      @(posedge clk); #1;
      if (!prev_b && bclk_a) begin
        rises++;
        chk("a_stable_counter", cnt_a, last_fall);
      end
      if (prev_b && !bclk_a) last_fall = cnt_a;
      if (done_a) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done: got done=1 expected none (t=%0t)", $time);
        end else begin
          e = qa.pop_front();
          chk("a_done_cycle", ncyc, e.cyc);
          chk("a_rise_count", rises, e.rises);
          chk("a_busy_at_done", busy_a, 0);
        end
      end
      if (!busy_a && !done_a) begin rises = 0; last_fall = 0; end
      prev_b = bclk_a;
    end
  end

  // monitor b: counter/round at every rise, word_first/word_last pulse counts
  initial begin : mon_b
    logic prev_b;
    int rises, nwf, nwl;
    done_exp_t e;
    rise_exp_t r;
    prev_b = 1'b0; rises = 0; nwf = 0; nwl = 0;
    forever begin
      @(posedge clk); #1;
      if (wf_b) nwf++;
      if (wl_b) nwl++;
      if (!prev_b && bclk_b) begin
        rises++;
        if (qr.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_rise: got rise expected none (t=%0t)", $time);
        end else begin
          r = qr.pop_front();
          chk("b_rise_counter", cnt_b, r.cnt);
          chk("b_rise_round", rnd_b, r.rnd);
        end
      end
      if (done_b) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done: got done=1 expected none (t=%0t)", $time);
        end else begin
          e = qb.pop_front();
          chk("b_done_cycle", ncyc, e.cyc);
          chk("b_rise_count", rises, e.rises);
          chk("b_word_first_count", nwf, 3);
          chk("b_word_last_count", nwl, 3);
        end
      end
      if (!busy_b && !done_b) begin rises = 0; nwf = 0; nwl = 0; end
      prev_b = bclk_b;
    end
  end

  initial begin : stim
    int n0;
    #2;
    chk("rst_bclk", bclk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_counter", cnt_a, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // small instance: 12 bits over 3 words, final fall at E24
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n0 = ncyc;
    chk("b_busy_e0", busy_b, 1);
    for (int i = 0; i < 12; i++) qr.push_back('{cnt: i % 4, rnd: i / 4});
    qb.push_back('{cyc: n0 + 24, rises: 12});
    repeat (30) @(posedge clk);

    // async reset in the middle of a job while bclk is high
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (50) @(posedge clk); #1;
    chk("mid_bclk_e50", bclk_a, 1);
    chk("mid_counter_e50", cnt_a, 12);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bclk", bclk_a, 0);
    chk("async_rst_counter", cnt_a, 0);
    chk("async_rst_round", rnd_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_done", done_a, 0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // full default job with ignored start pulses in RUN and in the DONE cycle
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n0 = ncyc;
    qa.push_back('{cyc: n0 + 8192, rises: 2048});
    chk("a_busy_e0", busy_a, 1);
    chk("a_bclk_e0", bclk_a, 0);
    @(posedge clk); #1 chk("a_bclk_e1", bclk_a, 0);
    @(posedge clk); #1 chk("a_bclk_e2", bclk_a, 1);
    repeat (998) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (7191) @(posedge clk);
    #1 chk("a_done_e8192", done_a, 1);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("a_done_one_cycle", done_a, 0);
    chk("a_busy_after_done_start", busy_a, 0);
    @(posedge clk); #1 chk("a_idle_after_done", busy_a, 0);

    // abort at E100, then a fresh job must be accepted
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (100) @(posedge clk); #1;
    chk("abort_pre_counter", cnt_a, 25);
    chk("abort_pre_busy", busy_a, 1);
    abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_bclk", bclk_a, 0);
    chk("abort_counter", cnt_a, 0);
    chk("abort_round", rnd_a, 0);
    repeat (5) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n0 = ncyc;
    qa.push_back('{cyc: n0 + 8192, rises: 2048});
    chk("restart_busy", busy_a, 1);
    repeat (8200) @(posedge clk);
    #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qr_drained", qr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
